// File: rtl/cond_unit.sv
// ============================================================================
//  Module   : cond_unit
//  Purpose  : NZCV flag register, ARM condition evaluation and write/branch
//             strobe gating. Optional macro COND_PERF_CNT_EN adds the
//             saturating execute/squash performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             cnt_clr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_cond_pass;
    logic       w_cond_ex;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Evaluated against the registered flags so an instruction never sees its own result
    always_comb begin
        w_cond_pass = 1'b0;
        case (Cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = ~(w_n ^ w_v);
            4'b1011: w_cond_pass = w_n ^ w_v;
            4'b1100: w_cond_pass = ~w_z & ~(w_n ^ w_v);
            4'b1101: w_cond_pass = w_z | (w_n ^ w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign w_cond_ex = in_valid & w_cond_pass;

    assign CondEx   = w_cond_ex;
    assign PCSrc    = PCS & w_cond_ex;
    assign MemWrite = MemW & w_cond_ex;
    assign RegWrite = RegW & w_cond_ex & ~NoWrite;
    assign Flags    = r_flags;

    // ALUFlags is only sampled under an enabled field write, keeping X out of the register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_cond_ex) begin
            if (FlagW[1]) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else if (cnt_clr) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else if (in_valid) begin
            if (w_cond_pass) begin
                if (r_exec_cnt != {CNT_W{1'b1}}) begin
                    r_exec_cnt <= r_exec_cnt + 1'b1;
                end
            end else begin
                if (r_squash_cnt != {CNT_W{1'b1}}) begin
                    r_squash_cnt <= r_squash_cnt + 1'b1;
                end
            end
        end
    end

    assign exec_cnt   = r_exec_cnt;
    assign squash_cnt = r_squash_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign exec_cnt         = '0;
    assign squash_cnt       = '0;
`endif

endmodule

`default_nettype wire

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Stage directly downstream of the ALU in the single-cycle ARM-subset datapath.
- Holds the architectural NZCV flag register and updates it from the ALU's {N,Z,C,V} output.
- Evaluates the instruction's 4-bit condition field against the stored flags, and gates the decoder's write/branch strobes so that failed-condition instructions have no architectural effect.
- Feeds PCSrc, RegWrite and MemWrite to the PC mux, register file and data memory.

Parameters:
- CNT_W, 16, width of the execute/squash performance counters (used only with COND_PERF_CNT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an instruction is present this cycle; low = bubble/stall.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle.
- FlagW  input  2  flag write enables from the decoder: [1] = N,Z; [0] = C,V.
- PCS  input  1  decoder: instruction writes PC.
- RegW  input  1  decoder: instruction writes the register file.
- MemW  input  1  decoder: instruction writes data memory.
- NoWrite  input  1  decoder: compare-type op (CMP/TST); suppresses RegWrite.
- cnt_clr  input  1  synchronous clear of the performance counters.
- PCSrc  output  1  gated PCS.
- RegWrite  output  1  gated RegW.
- MemWrite  output  1  gated MemW.
- CondEx  output  1  condition passed this cycle.
- Flags  output  4  current registered {N,Z,C,V}.
- exec_cnt  output  CNT_W  instructions executed.
- squash_cnt  output  CNT_W  instructions squashed by a failed condition.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Flags = 4'b0000; exec_cnt = 0; squash_cnt = 0.
  - Combinational outputs follow their equations from the reset flag state.
  - Reset mid-stream discards any pending flag update; the first edge after deassertion behaves normally.
- Condition evaluation is combinational against the registered Flags, not ALUFlags.
  - An instruction never sees its own flag result.
  - The next instruction sees it with 1-cycle latency.
- Cond encoding, CondEx = 1 when:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C & !Z. 1001 LS: !C | Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z & (N==V). 1101 LE: Z | (N!=V).
  - 1110 AL: 1. 1111 NV: 0 (reserved, never executes).
- CondEx is forced to 0 when in_valid = 0.
- Output gating, same cycle, zero latency:
  - PCSrc = PCS & CondEx.
  - MemWrite = MemW & CondEx.
  - RegWrite = RegW & CondEx & !NoWrite.
- Flag register update at the rising clk edge, only when in_valid & CondEx:
  - FlagW[1] set: Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0] set: Flags[1:0] <= ALUFlags[1:0].
  - Both set: all four bits update. Neither set: hold.
- Failed condition or bubble: flags hold, even if FlagW is nonzero.
- ALUFlags is ignored whenever no update occurs; X on ALUFlags must not propagate into Flags.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- Defined:
  - exec_cnt increments on in_valid & CondEx.
  - squash_cnt increments on in_valid & !CondEx.
  - Both counters saturate at all-ones; no wrap.
  - cnt_clr has priority over increment; the clear takes effect at the same edge.
- Not defined:
  - Counter logic is removed; exec_cnt and squash_cnt are tied to 0.
  - cnt_clr is ignored.
  - The port list is unchanged.

Test Plan:
- Reset, then Cond=0000 (EQ), RegW=1, in_valid=1 -> CondEx=0, RegWrite=0, Flags=0000.
- ALUFlags=0100, FlagW=11, Cond=1110 for 1 cycle, then Cond=0000, RegW=1 -> Flags=0100 after the edge; second cycle CondEx=1, RegWrite=1.
- Flags=0100; instruction with Cond=0001 (NE), FlagW=11, ALUFlags=1010 -> CondEx=0, Flags stays 0100; MemW=1 gives MemWrite=0.
- FlagW=10, ALUFlags=1011 from Flags=0000 -> Flags=1000 (C,V untouched); then Cond=1011 (LT) -> CondEx=1; Cond=1010 (GE) -> CondEx=0.
- CMP-style: RegW=1, NoWrite=1, Cond=1110, FlagW=11 -> RegWrite=0, flags update; in_valid=0 with FlagW=11 -> flags hold.
- COND_PERF_CNT_EN, CNT_W=4:
  - 20 executed instructions -> exec_cnt=15 (saturated).
  - cnt_clr together with an executed instruction -> exec_cnt=0 next cycle.
  - 3 failed-condition instructions -> squash_cnt=3.
